// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead FIFO read port and serialises
// them onto a UART line (LSB first, idle high, 8N1 by default).
// Optional build macro FIFO_UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit(s).
//
// Handshake: fifo_data is valid whenever fifo_empty is low; a pop happens on
// the rising edge where fifo_read_enable is high, and that same edge captures
// fifo_data into the shift register. fifo_read_enable is only raised in IDLE,
// so there is exactly one pop per frame.
// state_dbg exposes the FSM state encoding for checkers.
module fifo_uart_tx #(
    parameter int data_bus_length = 8,
    parameter int clks_per_bit    = 16,
    parameter int stop_bits       = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fifo_empty,
    input  logic [data_bus_length-1:0] fifo_data,
    output logic                       fifo_read_enable,
    output logic                       tx,
    output logic                       busy,
    output logic                       frame_done,
    output logic [2:0]                 state_dbg
);

    localparam int CW = $clog2(clks_per_bit);
    localparam int IW = (data_bus_length > 1) ? $clog2(data_bus_length) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(clks_per_bit - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(data_bus_length - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(stop_bits - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef FIFO_UART_TX_PARITY_EN
        ,S_PARITY = 3'd4
`endif
    } state_t;

    state_t                     state_q, state_nxt;
    logic [CW-1:0]              cnt_q, cnt_nxt;
    logic [IW-1:0]              idx_q, idx_nxt;
    logic [data_bus_length-1:0] shift_q, shift_nxt;
    logic                       tx_q, tx_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                       parity_q, parity_nxt;
`endif

    // State and datapath registers; tx is registered so the line never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            idx_q    <= idx_nxt;
            shift_q  <= shift_nxt;
            tx_q     <= tx_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_nxt;
`endif
        end
    end

    // Next-state logic: each bit lasts clks_per_bit cycles, counted down to 0.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        idx_nxt    = idx_q;
        shift_nxt  = shift_q;
        tx_nxt     = tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_nxt = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    state_nxt  = S_START;
                    shift_nxt  = fifo_data;
                    cnt_nxt    = CNT_LOAD;
                    tx_nxt     = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_nxt = ^fifo_data;
`endif
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = CNT_LOAD;
                    idx_nxt   = '0;
                    tx_nxt    = shift_q[0];
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_nxt = CNT_LOAD;
                    if (idx_q == IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
                        tx_nxt    = parity_q;
`else
                        state_nxt = S_STOP;
                        idx_nxt   = '0;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        shift_nxt = shift_q >> 1;
                        idx_nxt   = idx_q + 1'b1;
                        tx_nxt    = shift_q[1];
                    end
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_nxt = S_STOP;
                    cnt_nxt   = CNT_LOAD;
                    idx_nxt   = '0;
                    tx_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_nxt = 1'b1;
                if (cnt_q == '0) begin
                    cnt_nxt = CNT_LOAD;
                    if (idx_q == STOP_LAST) begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx_q + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // Outputs decoded from registered state; the pop is gated by reset so
    // nothing is consumed while the block is held in reset.
    always_comb begin
        fifo_read_enable = (state_q == S_IDLE) & ~fifo_empty & reset;
        busy             = (state_q != S_IDLE);
        frame_done       = (state_q == S_STOP) && (cnt_q == '0) && (idx_q == STOP_LAST);
        tx               = tx_q;
        state_dbg        = state_q;
    end

endmodule
